dmem_unit: RTL and testbench
============================

DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 Parameter DEPTH, default 128, data words in array (power of two, 16..4096).
REQ-002 Parameter READ_LAT, default 1, cycles from request acceptance to rsp_valid (1..4).
REQ-003 Localparam ADDR_W = log2(DEPTH)+2, byte-address width.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  unit can accept a request this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_op  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 req_sext  in  1  load sign-extends when 1, zero-extends when 0.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 rsp_valid  out  1  one-cycle pulse per accepted request.
REQ-014 rsp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-015 rsp_err  out  1  request rejected (misaligned or reserved op).
REQ-016 rsp_we  out  1  echo of req_we of the responding request.
REQ-017 init_done  out  1  array clear complete.
REQ-018 err_cnt  out  16  saturating count of rsp_err pulses.

Function
REQ-019 FSM states INIT, RUN; INIT writes 0 to word index init_ptr each cycle, init_ptr 0..DEPTH-1, then RUN.
REQ-020 req_ready = 1 only in RUN; init_done = 1 only in RUN.
REQ-021 Request accepted on edge where req_valid && req_ready; one request per cycle, no back-pressure in RUN.
REQ-022 Word index = req_addr[ADDR_W-1:2]; byte lane = req_addr[1:0].
REQ-023 Error when req_op = 11, half with addr[0] = 1, or word with addr[1:0] != 00; error store writes nothing.
REQ-024 Store byte: only lane addr[1:0] written with wdata[7:0]; half: lanes {addr[1],0} and {addr[1],1} written with wdata[15:0]; word: all lanes; other lanes unchanged (byte enables, no read-modify-write).
REQ-025 Store takes effect at acceptance edge; a load accepted on the next cycle observes it.
REQ-026 Load samples the array at acceptance edge, selects addressed lane(s), extends to 32 bits per req_sext; word ignores req_sext.
REQ-027 Response (valid, rdata, err, we) leaves a READ_LAT-deep shift pipeline; rsp_valid asserts exactly READ_LAT cycles after acceptance, in request order, for stores and loads.
REQ-028 err_cnt increments on each rsp_valid && rsp_err, holds at 16'hFFFF.

Reset
REQ-029 rstn low at an edge: state INIT, init_ptr 0, all pipeline valid bits 0, err_cnt 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, rsp_we 0, req_ready 0, init_done 0.
REQ-030 Reset during INIT restarts clearing from word 0; reset in RUN discards in-flight responses (no rsp_valid emitted for them).
REQ-031 After rstn release, req_ready rises exactly DEPTH cycles later; array reads all-zero thereafter until stored.

Structure
REQ-032 Package dm_pkg holds op encodings MEM_BYTE/MEM_HALF/MEM_WORD/MEM_RSV and the INIT/RUN state type.
REQ-033 Combinational sub-module dm_align: from op, addr[1:0], sext, wdata, array word produces byte enables, lane-shifted write data, extended load data, misalign flag.
REQ-034 Array is a single 32-bit × DEPTH register array, one write port, written by INIT or store, never both.

Verification
REQ-035 Reset release, DEPTH=128: req_ready low 128 cycles then high; load word 0x1FC -> rsp_rdata 0x00000000, rsp_err 0.
REQ-036 Store word 0x010 = 0x11223344; store byte 0x012 = 0xAA; load word 0x010 -> 0x11AA3344; load byte 0x012 sext=1 -> 0xFFFFFFAA, sext=0 -> 0x000000AA.
REQ-037 Store half 0x022 = 0x8001; load half 0x022 sext=1 -> 0xFFFF8001; load half 0x020 -> 0x00000000.
REQ-038 Load word 0x013, store half 0x031, op=11 at 0x040 -> three rsp_err pulses, err_cnt = 3, word 0x030 unchanged 0.
REQ-039 READ_LAT=3, back-to-back store 0x050=0xDEADBEEF then load 0x050: rsp_valid at +3 and +4 cycles, second rdata 0xDEADBEEF.
REQ-040 Reset asserted with two loads in flight: no rsp_valid for them; after re-INIT, load 0x010 -> 0x00000000.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings for the data memory unit: access sizes, FSM states, response record.
// No logic; types and constants only.
// Not applicable (no flow control lives here).
package dm_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSV  = 2'b11
  } mem_op_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dm_state_e;

  // One response slot travelling down the read-latency pipeline.
  typedef struct packed {
    logic        vld;
    logic        we;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

endpackage

// File: rtl/dm_align.sv
// Lane steering for sub-word accesses: byte enables, replicated store data, extended load data.
// Purely combinational, zero latency.
// No flow control; the caller decides when the outputs are used.
module dm_align import dm_pkg::*; (
  input  logic [1:0]  i_op,
  input  logic [1:0]  i_lane,
  input  logic        i_sext,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

  // Store data is replicated across lanes so the byte enables alone pick the target lanes.
  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = '0;
    o_rdata    = '0;
    o_misalign = 1'b0;
    case (i_op)
      MEM_BYTE: begin
        o_be    = 4'b0001 << i_lane;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_sext & w_byte[7]}}, w_byte};
      end
      MEM_HALF: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_sext & w_half[15]}}, w_half};
        if (i_lane[0]) o_misalign = 1'b1;
        else           o_be       = i_lane[1] ? 4'b1100 : 4'b0011;
      end
      MEM_WORD: begin
        o_wdata = i_wdata;
        o_rdata = i_rword;
        if (i_lane != 2'b00) o_misalign = 1'b1;
        else                 o_be       = 4'b1111;
      end
      default: begin
        o_be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_unit.sv
// Byte-addressed data memory with sized loads/stores; clears itself to zero after reset.
// Response appears READ_LAT cycles after acceptance, in order, one per request.
// No back-pressure once running; req_ready is low only while the array is being cleared.
module dmem_unit import dm_pkg::*; #(
  parameter  int DEPTH    = 128,
  parameter  int READ_LAT = 1,
  localparam int ADDR_W   = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_op,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_we,
  output logic              init_done,
  output logic [15:0]       err_cnt
);

  localparam int IDX_W = ADDR_W - 2;

  dm_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0] r_init_ptr, w_init_ptr_nxt;
  logic [IDX_W-1:0] w_idx, w_mem_idx;
  logic [3:0]       w_be, w_mem_be;
  logic [31:0]      w_wdata_sh, w_mem_wdata, w_rword, w_ld_data;
  logic             w_mem_we, w_misalign, w_err, w_acc;
  logic [31:0]      r_mem [DEPTH];
  rsp_t             r_pipe [READ_LAT];
  rsp_t             w_rsp_in;
  logic [15:0]      r_err_cnt;

  assign w_idx   = req_addr[ADDR_W-1:2];
  assign w_rword = r_mem[w_idx];
  assign w_err   = w_misalign | (req_op == MEM_RSV);
  assign w_acc   = req_valid & req_ready;

  dm_align u_align (
    .i_op       (req_op),
    .i_lane     (req_addr[1:0]),
    .i_sext     (req_sext),
    .i_wdata    (req_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wdata_sh),
    .o_rdata    (w_ld_data),
    .o_misalign (w_misalign)
  );

  // State and clear pointer; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= INIT;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
    end
  end

  // Next state plus the single write-port mux: clearing owns the port in INIT, stores in RUN.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    req_ready      = 1'b0;
    init_done      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_idx      = w_idx;
    w_mem_be       = w_be;
    w_mem_wdata    = w_wdata_sh;
    case (r_state)
      INIT: begin
        w_mem_we       = 1'b1;
        w_mem_idx      = r_init_ptr;
        w_mem_be       = 4'b1111;
        w_mem_wdata    = '0;
        w_init_ptr_nxt = r_init_ptr + 1'b1;
        if (r_init_ptr == IDX_W'(DEPTH - 1)) w_state_nxt = RUN;
      end
      RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
        w_mem_we  = req_valid & req_we & ~w_err;
      end
      default: w_state_nxt = INIT;
    endcase
  end

  // Byte-enabled array write; untouched lanes keep their contents.
  always_ff @(posedge clk) begin
    if (rstn && w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mem_be[b]) r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
      end
    end
  end

  // Response captured at acceptance; rdata forced to 0 for stores and rejected requests.
  always_comb begin
    w_rsp_in = '0;
    if (w_acc) begin
      w_rsp_in.vld   = 1'b1;
      w_rsp_in.we    = req_we;
      w_rsp_in.err   = w_err;
      w_rsp_in.rdata = (!req_we && !w_err) ? w_ld_data : 32'h0;
    end
  end

  // Read-latency shift pipeline; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < READ_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_rsp_in;
      for (int i = 1; i < READ_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign rsp_valid = r_pipe[READ_LAT-1].vld;
  assign rsp_we    = r_pipe[READ_LAT-1].we;
  assign rsp_err   = r_pipe[READ_LAT-1].err;
  assign rsp_rdata = r_pipe[READ_LAT-1].rdata;

  // Saturating count of error responses as they leave the pipeline.
  always_ff @(posedge clk) begin
    if (!rstn)                                             r_err_cnt <= '0;
    else if (rsp_valid && rsp_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench: two instances (READ_LAT 1 and 3) share one request stream.
// Checks clear timing, sized loads/stores, errors, latency and reset flushing.
// Requests are driven back-to-back; the unit never stalls once running.
module tb_dmem_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_we, req_sext;
  logic [1:0]  req_op;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;

  logic        rdy1, v1, e1, we1, done1;
  logic [31:0] d1;
  logic [15:0] ec1;
  logic        rdy3, v3, e3, we3, done3;
  logic [31:0] d3;
  logic [15:0] ec3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_unit #(.DEPTH(128), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_op(req_op), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v1), .rsp_rdata(d1), .rsp_err(e1), .rsp_we(we1), .init_done(done1), .err_cnt(ec1)
  );

  dmem_unit #(.DEPTH(128), .READ_LAT(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
    .req_op(req_op), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v3), .rsp_rdata(d3), .rsp_err(e3), .rsp_we(we3), .init_done(done3), .err_cnt(ec3)
  );

  typedef struct {
    logic        we;
    logic [1:0]  op;
    logic        sext;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready with a bounded budget; counts any response seen on the way.
  task automatic wait_ready(output int n, output int spur);
    n = 0;
    spur = 0;
    while (!rdy1 && n < 300) begin
      tick();
      n++;
      if (v1 || v3) spur++;
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] op, input logic sext,
                       input logic [8:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_sext  = sext;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_op    = 2'b00;
    req_sext  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  initial begin
    int n, spur;
    int seen_k [$];

    tv[0]  = '{1'b0, 2'b10, 1'b0, 9'h1FC, 32'h0,        32'h00000000, 1'b0};
    tv[1]  = '{1'b1, 2'b10, 1'b0, 9'h010, 32'h11223344, 32'h00000000, 1'b0};
    tv[2]  = '{1'b1, 2'b00, 1'b0, 9'h012, 32'h000000AA, 32'h00000000, 1'b0};
    tv[3]  = '{1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        32'h11AA3344, 1'b0};
    tv[4]  = '{1'b0, 2'b00, 1'b1, 9'h012, 32'h0,        32'hFFFFFFAA, 1'b0};
    tv[5]  = '{1'b0, 2'b00, 1'b0, 9'h012, 32'h0,        32'h000000AA, 1'b0};
    tv[6]  = '{1'b1, 2'b01, 1'b0, 9'h022, 32'h00008001, 32'h00000000, 1'b0};
    tv[7]  = '{1'b0, 2'b01, 1'b1, 9'h022, 32'h0,        32'hFFFF8001, 1'b0};
    tv[8]  = '{1'b0, 2'b01, 1'b1, 9'h020, 32'h0,        32'h00000000, 1'b0};
    tv[9]  = '{1'b0, 2'b10, 1'b0, 9'h013, 32'h0,        32'h00000000, 1'b1};
    tv[10] = '{1'b1, 2'b01, 1'b0, 9'h031, 32'h0000BEEF, 32'h00000000, 1'b1};
    tv[11] = '{1'b0, 2'b11, 1'b0, 9'h040, 32'h0,        32'h00000000, 1'b1};
    tv[12] = '{1'b0, 2'b10, 1'b0, 9'h030, 32'h0,        32'h00000000, 1'b0};
    tv[13] = '{1'b0, 2'b01, 1'b0, 9'h012, 32'h0,        32'h000011AA, 1'b0};
    tv[14] = '{1'b0, 2'b00, 1'b1, 9'h013, 32'h0,        32'h00000011, 1'b0};
    tv[15] = '{1'b0, 2'b01, 1'b0, 9'h022, 32'h0,        32'h00008001, 1'b0};
    tv[16] = '{1'b1, 2'b00, 1'b1, 9'h011, 32'h000001FF, 32'h00000000, 1'b0};
    tv[17] = '{1'b0, 2'b10, 1'b1, 9'h010, 32'h0,        32'h11AAFF44, 1'b0};

    // Reset state.
    idle();
    rstn = 1'b0;
    tick();
    tick();
    chk("rst_ready",  {31'b0, rdy1}, 32'd0);
    chk("rst_done",   {31'b0, done1}, 32'd0);
    chk("rst_valid",  {30'b0, v1, v3}, 32'd0);
    chk("rst_rdata",  d1 | d3, 32'd0);
    chk("rst_errwe",  {28'b0, e1, we1, e3, we3}, 32'd0);
    chk("rst_errcnt", {ec1, ec3}, 32'd0);

    // Reset partway through clearing restarts the full clear.
    rstn = 1'b1;
    repeat (50) tick();
    chk("mid_init_ready", {31'b0, rdy1}, 32'd0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    wait_ready(n, spur);
    chk("init_cycles", n, 32'd128);
    chk("init_done_both", {30'b0, done1, done3}, 32'd3);
    chk("ready3", {31'b0, rdy3}, 32'd1);

    // Back-to-back table on the single-cycle instance.
    for (int i = 0; i < 18; i++) begin
      drive(tv[i].we, tv[i].op, tv[i].sext, tv[i].addr, tv[i].wdata);
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, v1}, 32'd1);
      chk($sformatf("v%0d_rdata", i), d1, tv[i].rdata);
      chk($sformatf("v%0d_err", i),   {31'b0, e1}, {31'b0, tv[i].err});
      chk($sformatf("v%0d_we", i),    {31'b0, we1}, {31'b0, tv[i].we});
    end
    idle();
    repeat (5) tick();
    chk("idle_valid", {30'b0, v1, v3}, 32'd0);
    chk("errcnt1", {16'b0, ec1}, 32'd3);
    chk("errcnt3", {16'b0, ec3}, 32'd3);

    // Store then load back-to-back; watch both latencies.
    drive(1'b1, 2'b10, 1'b0, 9'h050, 32'hDEADBEEF);
    tick();
    chk("lat1_st_valid", {31'b0, v1}, 32'd1);
    chk("lat1_st_we",    {31'b0, we1}, 32'd1);
    drive(1'b0, 2'b10, 1'b0, 9'h050, 32'h0);
    for (int k = 2; k <= 7; k++) begin
      tick();
      if (k == 2) begin
        idle();
        chk("lat1_ld_valid", {31'b0, v1}, 32'd1);
        chk("lat1_ld_rdata", d1, 32'hDEADBEEF);
      end
      if (v3) seen_k.push_back(k);
      if (k == 3) chk("lat3_st_we", {31'b0, we3}, 32'd1);
      if (k == 4) begin
        chk("lat3_ld_we",    {31'b0, we3}, 32'd0);
        chk("lat3_ld_rdata", d3, 32'hDEADBEEF);
      end
    end
    chk("lat3_pulses", seen_k.size(), 32'd2);
    if (seen_k.size() == 2) begin
      chk("lat3_first_k",  seen_k[0], 32'd3);
      chk("lat3_second_k", seen_k[1], 32'd4);
    end

    // Reset with loads in flight on the 3-cycle instance.
    drive(1'b0, 2'b10, 1'b0, 9'h010, 32'h0);
    tick();
    tick();
    idle();
    rstn = 1'b0;
    tick();
    chk("flush_valid", {30'b0, v1, v3}, 32'd0);
    tick();
    rstn = 1'b1;
    wait_ready(n, spur);
    chk("reinit_cycles", n, 32'd128);
    chk("flush_spurious", spur, 32'd0);
    chk("reinit_errcnt", {ec1, ec3}, 32'd0);
    drive(1'b0, 2'b10, 1'b0, 9'h010, 32'h0);
    tick();
    idle();
    chk("reinit_ld1_valid", {31'b0, v1}, 32'd1);
    chk("reinit_ld1_rdata", d1, 32'h0);
    tick();
    tick();
    chk("reinit_ld3_valid", {31'b0, v3}, 32'd1);
    chk("reinit_ld3_rdata", d3, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
